id_decode_queue: RTL and testbench

//  Parametrised decode-stage controller for the MIPS core: decodes each fetched instruction into a compact

---
 rtl/id_decode_queue.sv | 261 ++++++++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// Decode-stage controller: decodes fetched MIPS words into control bundles, queues them and issues to EXE,
// holding HI/LO users behind an in-flight MULT/DIV and masking reserved-instruction traps just after reset.
module id_decode_queue #(
    parameter int DEPTH    = 4,
    parameter int RST_MASK = 1,
    parameter bit EN_MUL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        in_exc,
    input  logic [4:0]  in_exccode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_rf_wr,
    output logic        out_dm_rd,
    output logic        out_dm_wr,
    output logic [2:0]  out_dm_sel,
    output logic [3:0]  out_alu_op,
    output logic        out_is_br,
    output logic        out_start,
    output logic        out_exc,
    output logic [4:0]  out_exccode,
    input  logic        muldiv_done,
    output logic        muldiv_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int MW = $clog2(RST_MASK + 2);

    typedef struct packed {
        logic       rf_wr;
        logic       dm_rd;
        logic       dm_wr;
        logic [2:0] dm_sel;
        logic [3:0] alu_op;
        logic       is_br;
        logic       start;
        logic       exc;
        logic [4:0] exccode;
        logic       rhl_visit;
    } bundle_t;

    localparam bundle_t IDLE_B = '{rf_wr: 1'b0, dm_rd: 1'b0, dm_wr: 1'b0, dm_sel: 3'd7, alu_op: 4'd15,
                                   is_br: 1'b0, start: 1'b0, exc: 1'b0, exccode: 5'd0, rhl_visit: 1'b0};

    function automatic bundle_t alu_wr(input logic [3:0] op);
        bundle_t b;
        b = IDLE_B;
        b.rf_wr  = 1'b1;
        b.alu_op = op;
        return b;
    endfunction

    // Loads and stores compute their address with a non-trapping add.
    function automatic bundle_t mem_acc(input logic wr, input logic [2:0] sel);
        bundle_t b;
        b = IDLE_B;
        b.rf_wr  = ~wr;
        b.dm_rd  = ~wr;
        b.dm_wr  = wr;
        b.dm_sel = sel;
        b.alu_op = 4'd11;
        return b;
    endfunction

    function automatic bundle_t ctl(input logic rf, input logic br, input logic st, input logic rhl);
        bundle_t b;
        b = IDLE_B;
        b.rf_wr     = rf;
        b.is_br     = br;
        b.start     = st;
        b.rhl_visit = rhl;
        return b;
    endfunction

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic        unused_s;
    bundle_t     dec_s;
    logic        legal_s;
    logic        brk_s;
    logic        sys_s;
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    bundle_t     mem_r [DEPTH];
    bundle_t     head_s;
    bundle_t     out_b_s;
    logic        busy_r;
    logic [MW-1:0] mask_r;
    logic        empty_s;
    logic        full_s;
    logic        hold_s;
    logic        push_s;
    logic        pop_s;

    assign op_s     = in_instr[31:26];
    assign rs_s     = in_instr[25:21];
    assign rt_s     = in_instr[20:16];
    assign funct_s  = in_instr[5:0];
    assign unused_s = ^in_instr[15:6];

    // Instruction decode and exception selection for the word being pushed
    always_comb begin
        dec_s   = IDLE_B;
        legal_s = 1'b1;
        brk_s   = 1'b0;
        sys_s   = 1'b0;
        case (op_s)
            6'h00: begin
                case (funct_s)
                    6'h20:        dec_s = alu_wr(4'd0);
                    6'h21:        dec_s = alu_wr(4'd11);
                    6'h22:        dec_s = alu_wr(4'd1);
                    6'h23:        dec_s = alu_wr(4'd12);
                    6'h24:        dec_s = alu_wr(4'd3);
                    6'h25:        dec_s = alu_wr(4'd2);
                    6'h26:        dec_s = alu_wr(4'd5);
                    6'h27:        dec_s = alu_wr(4'd4);
                    6'h2a:        dec_s = alu_wr(4'd9);
                    6'h2b:        dec_s = alu_wr(4'd10);
                    6'h00, 6'h04: dec_s = alu_wr(4'd6);
                    6'h02, 6'h06: dec_s = alu_wr(4'd7);
                    6'h03, 6'h07: dec_s = alu_wr(4'd8);
                    6'h08:        dec_s = ctl(1'b0, 1'b1, 1'b0, 1'b0);
                    6'h09:        dec_s = ctl(1'b1, 1'b1, 1'b0, 1'b0);
                    6'h0c:        sys_s = 1'b1;
                    6'h0d:        brk_s = 1'b1;
                    6'h10, 6'h12: dec_s = ctl(1'b1, 1'b0, 1'b0, 1'b1);
                    6'h11, 6'h13: dec_s = ctl(1'b0, 1'b0, 1'b0, 1'b1);
                    6'h18, 6'h19, 6'h1a, 6'h1b: dec_s = ctl(1'b0, 1'b0, 1'b1, 1'b1);
                    default:      legal_s = 1'b0;
                endcase
            end
            6'h01: begin
                case (rt_s)
                    5'h00, 5'h01: dec_s = ctl(1'b0, 1'b1, 1'b0, 1'b0);
                    5'h10, 5'h11: dec_s = ctl(1'b1, 1'b1, 1'b0, 1'b0);
                    default:      legal_s = 1'b0;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: dec_s = ctl(1'b0, 1'b1, 1'b0, 1'b0);
            6'h03: dec_s = ctl(1'b1, 1'b1, 1'b0, 1'b0);
            6'h08: dec_s = alu_wr(4'd0);
            6'h09: dec_s = alu_wr(4'd11);
            6'h0a: dec_s = alu_wr(4'd9);
            6'h0b: dec_s = alu_wr(4'd10);
            6'h0c: dec_s = alu_wr(4'd3);
            6'h0d, 6'h0f: dec_s = alu_wr(4'd2);
            6'h0e: dec_s = alu_wr(4'd5);
            6'h10: begin
                if (rs_s == 5'h00) begin
                    dec_s = ctl(1'b1, 1'b0, 1'b0, 1'b0);
                end else if ((rs_s == 5'h04) || ((rs_s == 5'h10) && (funct_s == 6'h18))) begin
                    legal_s = 1'b1;
                end else begin
                    legal_s = 1'b0;
                end
            end
            6'h1c: begin
                if (EN_MUL && (funct_s == 6'h02)) begin
                    dec_s = ctl(1'b1, 1'b0, 1'b1, 1'b0);
                end else begin
                    legal_s = 1'b0;
                end
            end
            6'h20: dec_s = mem_acc(1'b0, 3'd4);
            6'h21: dec_s = mem_acc(1'b0, 3'd6);
            6'h23: dec_s = mem_acc(1'b0, 3'd2);
            6'h24: dec_s = mem_acc(1'b0, 3'd3);
            6'h25: dec_s = mem_acc(1'b0, 3'd5);
            6'h28: dec_s = mem_acc(1'b1, 3'd0);
            6'h29: dec_s = mem_acc(1'b1, 3'd1);
            6'h2b: dec_s = mem_acc(1'b1, 3'd2);
            default: legal_s = 1'b0;
        endcase

        if (in_exc) begin
            dec_s.exc     = 1'b1;
            dec_s.exccode = in_exccode;
        end else if (!legal_s && (mask_r == {MW{1'b0}})) begin
            dec_s.exc     = 1'b1;
            dec_s.exccode = 5'h0a;
        end else if (brk_s) begin
            dec_s.exc     = 1'b1;
            dec_s.exccode = 5'h09;
        end else if (sys_s) begin
            dec_s.exc     = 1'b1;
            dec_s.exccode = 5'h08;
        end else begin
            dec_s.exc     = 1'b0;
            dec_s.exccode = 5'h00;
        end
        // An excepting entry must not commit any architectural side effect.
        dec_s.rf_wr = dec_s.rf_wr & ~dec_s.exc;
        dec_s.dm_rd = dec_s.dm_rd & ~dec_s.exc;
        dec_s.dm_wr = dec_s.dm_wr & ~dec_s.exc;
        dec_s.start = dec_s.start & ~dec_s.exc;
    end

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s  = mem_r[rd_ptr_r[AW-1:0]];
    assign hold_s  = head_s.rhl_visit & busy_r;
    assign push_s  = in_valid & ~full_s & ~flush;
    assign pop_s   = ~empty_s & ~hold_s & out_ready;
    assign out_b_s = empty_s ? IDLE_B : head_s;

    // Queue storage; contents are only observed through the valid pointer window
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= dec_s;
        end
    end

    // Pointers, HI/LO scoreboard and post-reset RI mask counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            busy_r   <= 1'b0;
            mask_r   <= MW'(RST_MASK);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (flush) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            end
            if (pop_s && head_s.start) begin
                busy_r <= 1'b1;
            end else if (muldiv_done) begin
                busy_r <= 1'b0;
            end
            if (mask_r != {MW{1'b0}}) begin
                mask_r <= mask_r - MW'(1);
            end
        end
    end

    assign in_ready    = ~full_s;
    assign out_valid   = ~empty_s & ~hold_s;
    assign muldiv_busy = busy_r;
    assign out_rf_wr   = out_b_s.rf_wr;
    assign out_dm_rd   = out_b_s.dm_rd;
    assign out_dm_wr   = out_b_s.dm_wr;
    assign out_dm_sel  = out_b_s.dm_sel;
    assign out_alu_op  = out_b_s.alu_op;
    assign out_is_br   = out_b_s.is_br;
    assign out_start   = out_b_s.start;
    assign out_exc     = out_b_s.exc;
    assign out_exccode = out_b_s.exccode;

endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: directed scenarios followed by random traffic, all checked against a
// table-driven instruction model and an ordered queue/scoreboard model.
module tb_id_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        in_exc = 1'b0;
    logic [4:0]  in_exccode = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_rf_wr, out_dm_rd, out_dm_wr, out_is_br, out_start, out_exc;
    logic [2:0]  out_dm_sel;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_exccode;
    logic        muldiv_done = 1'b0;
    logic        muldiv_busy;

    id_decode_queue #(.DEPTH(DEPTH), .RST_MASK(1), .EN_MUL(1'b0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_exc(in_exc), .in_exccode(in_exccode), .out_valid(out_valid),
        .out_ready(out_ready), .out_rf_wr(out_rf_wr), .out_dm_rd(out_dm_rd), .out_dm_wr(out_dm_wr),
        .out_dm_sel(out_dm_sel), .out_alu_op(out_alu_op), .out_is_br(out_is_br), .out_start(out_start),
        .out_exc(out_exc), .out_exccode(out_exccode), .muldiv_done(muldiv_done), .muldiv_busy(muldiv_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rf, dmrd, dmwr;
        logic [2:0] sel;
        logic [3:0] alu;
        logic       br, st, exc;
        logic [4:0] code;
        logic       rhl;
    } mb_t;

    // kind: 0 ordinary, 2 BREAK, 3 SYSCALL; words matching no entry are reserved
    typedef struct {
        logic [31:0] base;
        logic [31:0] mask;
        mb_t         b;
        int          kind;
    } tm_t;

    localparam logic [31:0] RM = 32'hFC00003F;
    localparam logic [31:0] IM = 32'hFC000000;
    localparam logic [31:0] BM = 32'hFC1F0000;
    localparam logic [31:0] CM = 32'hFFE00000;

    tm_t  tq[$];
    mb_t  q[$];
    logic busy_m;
    int   mask_m;
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [31:0] base, input logic [31:0] mask, input int rf, input int dr,
                       input int dw, input int sel, input int alu, input int br, input int st,
                       input int rhl, input int kind);
        tm_t t;
        t.base = base;
        t.mask = mask;
        t.b    = '{rf: 1'(rf), dmrd: 1'(dr), dmwr: 1'(dw), sel: 3'(sel), alu: 4'(alu), br: 1'(br),
                   st: 1'(st), exc: 1'b0, code: 5'd0, rhl: 1'(rhl)};
        t.kind = kind;
        tq.push_back(t);
    endtask

    task automatic build_table();
        int ralu [16] = '{0, 11, 1, 12, 3, 2, 5, 4, 9, 10, 6, 6, 7, 7, 8, 8};
        int rfn  [16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 0, 4, 2, 6, 3, 7};
        int iop  [8]  = '{'h08, 'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f};
        int ialu [8]  = '{0, 11, 9, 10, 3, 2, 5, 2};
        int lop  [5]  = '{'h20, 'h21, 'h23, 'h24, 'h25};
        int lsel [5]  = '{4, 6, 2, 3, 5};
        int sop  [3]  = '{'h28, 'h29, 'h2b};
        for (int i = 0; i < 16; i++) add(32'(rfn[i]), RM, 1, 0, 0, 7, ralu[i], 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)  add(32'(iop[i]) << 26, IM, 1, 0, 0, 7, ialu[i], 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)  add(32'(lop[i]) << 26, IM, 1, 1, 0, lsel[i], 11, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)  add(32'(sop[i]) << 26, IM, 0, 0, 1, i, 11, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)  add(32'(i + 'h18), RM, 0, 0, 0, 7, 15, 0, 1, 1, 0);
        add(32'h00000008, RM, 0, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h00000009, RM, 1, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h0000000C, RM, 0, 0, 0, 7, 15, 0, 0, 0, 3);
        add(32'h0000000D, RM, 0, 0, 0, 7, 15, 0, 0, 0, 2);
        add(32'h00000010, RM, 1, 0, 0, 7, 15, 0, 0, 1, 0);
        add(32'h00000012, RM, 1, 0, 0, 7, 15, 0, 0, 1, 0);
        add(32'h00000011, RM, 0, 0, 0, 7, 15, 0, 0, 1, 0);
        add(32'h00000013, RM, 0, 0, 0, 7, 15, 0, 0, 1, 0);
        add(32'h08000000, IM, 0, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h0C000000, IM, 1, 0, 0, 7, 15, 1, 0, 0, 0);
        for (int i = 4; i < 8; i++)  add(32'(i) << 26, IM, 0, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h04000000, BM, 0, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h04010000, BM, 0, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h04100000, BM, 1, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h04110000, BM, 1, 0, 0, 7, 15, 1, 0, 0, 0);
        add(32'h40000000, CM, 1, 0, 0, 7, 15, 0, 0, 0, 0);
        add(32'h40800000, CM, 0, 0, 0, 7, 15, 0, 0, 0, 0);
        add(32'h42000018, 32'hFFE0003F, 0, 0, 0, 7, 15, 0, 0, 0, 0);
    endtask

    function automatic mb_t expect_of(input logic [31:0] w, input logic e, input logic [4:0] c,
                                      input logic sup);
        mb_t b;
        int  kind;
        b = '{rf: 1'b0, dmrd: 1'b0, dmwr: 1'b0, sel: 3'd7, alu: 4'd15, br: 1'b0, st: 1'b0,
              exc: 1'b0, code: 5'd0, rhl: 1'b0};
        kind = 1;
        foreach (tq[i]) begin
            if ((w & tq[i].mask) == tq[i].base) begin
                b    = tq[i].b;
                kind = tq[i].kind;
            end
        end
        if (e)                        begin b.exc = 1'b1; b.code = c;      end
        else if (kind == 1 && !sup)   begin b.exc = 1'b1; b.code = 5'h0a;  end
        else if (kind == 2)           begin b.exc = 1'b1; b.code = 5'h09;  end
        else if (kind == 3)           begin b.exc = 1'b1; b.code = 5'h08;  end
        if (b.exc) begin
            b.rf = 1'b0; b.dmrd = 1'b0; b.dmwr = 1'b0; b.st = 1'b0;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        mb_t  e;
        logic v;
        e = '{rf: 1'b0, dmrd: 1'b0, dmwr: 1'b0, sel: 3'd7, alu: 4'd15, br: 1'b0, st: 1'b0,
              exc: 1'b0, code: 5'd0, rhl: 1'b0};
        v = 1'b0;
        if (q.size() != 0) begin
            e = q[0];
            v = !(q[0].rhl && busy_m);
        end
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("muldiv_busy", 32'(muldiv_busy), 32'(busy_m));
        chk("bundle", 32'({out_rf_wr, out_dm_rd, out_dm_wr, out_dm_sel, out_alu_op, out_is_br, out_start,
                           out_exc, out_exccode}),
            32'({e.rf, e.dmrd, e.dmwr, e.sel, e.alu, e.br, e.st, e.exc, e.code}));
    endtask

    // One clock: drive inputs, advance the model, then check at the following falling edge.
    task automatic step(input logic v, input logic [31:0] w, input logic e, input logic [4:0] c,
                        input logic rdy, input logic dn, input logic fl);
        logic hold_m, pop_m, push_m;
        mb_t  pushed;
        in_valid = v; in_instr = w; in_exc = e; in_exccode = c;
        out_ready = rdy; muldiv_done = dn; flush = fl;
        hold_m = 1'b0;
        if (q.size() != 0) hold_m = q[0].rhl && busy_m;
        pop_m  = (q.size() != 0) && !hold_m && rdy;
        push_m = v && (q.size() < DEPTH) && !fl;
        pushed = expect_of(w, e, c, mask_m != 0);
        if (pop_m && q[0].st) busy_m = 1'b1;
        else if (dn)          busy_m = 1'b0;
        if (fl) q.delete();
        else begin
            if (pop_m)  void'(q.pop_front());
            if (push_m) q.push_back(pushed);
        end
        if (mask_m != 0) mask_m--;
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic push(input logic [31:0] w, input logic rdy);
        step(1'b1, w, 1'b0, 5'd0, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic dn);
        step(1'b0, 32'h0, 1'b0, 5'd0, rdy, dn, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        busy_m = 1'b0;
        mask_m = 1;
    endtask

    initial begin
        logic [3:0]  alus [4] = '{4'd11, 4'd12, 4'd3, 4'd2};
        logic [31:0] w;
        build_table();
        model_reset();
        repeat (2) @(negedge clk);
        check_model();
        chk("rst_sel", 32'(out_dm_sel), 32'd7);
        chk("rst_alu", 32'(out_alu_op), 32'd15);
        rst = 1'b0;

        // reserved word masked in the first cycle, trapped by cycle 3
        push(32'hFFFFFFFF, 1'b0);
        chk("t1_masked", 32'(out_exc), 32'd0);
        idle(1'b1, 1'b0);
        push(32'hFFFFFFFF, 1'b0);
        chk("t1_ri_exc", 32'(out_exc), 32'd1);
        chk("t1_ri_code", 32'(out_exccode), 32'h0a);
        idle(1'b1, 1'b0);

        // fill to full, then drain in order
        push(32'h00221821, 1'b0);
        push(32'h00221823, 1'b0);
        push(32'h00221824, 1'b0);
        push(32'h00221825, 1'b0);
        chk("t2_full", 32'(in_ready), 32'd0);
        push(32'h00221826, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(out_alu_op), 32'(alus[i]));
            idle(1'b1, 1'b0);
        end
        chk("t2_drained", 32'(out_valid), 32'd0);

        // MFLO waits behind MULT
        push(32'h02110018, 1'b0);
        push(32'h00004012, 1'b1);
        chk("t3_held", 32'(out_valid), 32'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("t3_still_held", 32'(out_valid), 32'd0);
        idle(1'b1, 1'b1);
        chk("t3_released", 32'(out_valid), 32'd1);
        idle(1'b1, 1'b0);
        chk("t3_popped", 32'(out_valid), 32'd0);

        // done coincident with a new DIV issue keeps the scoreboard busy
        push(32'h0211001A, 1'b0);
        step(1'b1, 32'h00004010, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        chk("t4_busy", 32'(muldiv_busy), 32'd1);
        chk("t4_mfhi_held", 32'(out_valid), 32'd0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // flush drops queue and the concurrent push
        push(32'h00221821, 1'b0);
        push(32'h00221823, 1'b0);
        push(32'h00221824, 1'b0);
        step(1'b1, 32'h00221825, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("t5_empty", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        idle(1'b0, 1'b0);
        chk("t5_no_push", 32'(out_valid), 32'd0);

        // exception priority
        step(1'b1, 32'h0000000C, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        chk("t6_fetch_code", 32'(out_exccode), 32'd4);
        idle(1'b1, 1'b0);
        push(32'h0000000C, 1'b0);
        chk("t6_syscall", 32'(out_exccode), 32'd8);
        idle(1'b1, 1'b0);
        push(32'h70430802, 1'b0);
        chk("t6_mul_ri", 32'(out_exccode), 32'h0a);
        idle(1'b1, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                w = tq[$urandom_range(0, tq.size() - 1)].base;
                w = w | ($urandom & ~tq[$urandom_range(0, tq.size() - 1)].mask);
                w = ($urandom_range(0, 3) == 0) ? w : (w & ~IM) | (w & IM);
            end else begin
                w = $urandom;
            end
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 9) == 0),
                 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

        // reset in the middle of traffic
        push(32'h02110018, 1'b1);
        push(32'h00004012, 1'b0);
        push(32'h00221821, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
        push(32'hFFFFFFFF, 1'b0);
        chk("rst2_masked", 32'(out_exc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
